// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Purpose  : Linear frequency-sweep sequencer for an NCO. Steps the tuning
//            word from a start value by a fixed increment, holding each word
//            for a programmed dwell, and strobes o_ftw_load on every new word.
// Options  : NCO_SWEEP_BIDIR_EN - adds i_bidir; the sweep then runs back
//            down to the start word after reaching the top.
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
  parameter int FTW_W   = 24,
  parameter int CNT_W   = 12,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [FTW_W-1:0]   i_ftw_start,
  input  logic [FTW_W-1:0]   i_ftw_step,
  input  logic [CNT_W-1:0]   i_step_count,
  input  logic [DWELL_W-1:0] i_dwell,
`ifdef NCO_SWEEP_BIDIR_EN
  input  logic               i_bidir,
`endif
  output logic [FTW_W-1:0]   o_ftw_out,
  output logic               o_ftw_load,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_RUN    = 2'd1;
  localparam logic [1:0] c_S_DONE   = 2'd2;
`ifdef NCO_SWEEP_BIDIR_EN
  localparam logic [1:0] c_S_RUN_DN = 2'd3;
`endif

  localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
  localparam logic [DWELL_W-1:0] c_DWELL_ONE = DWELL_W'(1);

  logic [1:0]         r_state;
  logic [FTW_W-1:0]   r_ftw;
  logic [FTW_W-1:0]   r_step;
  logic [CNT_W-1:0]   r_count;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_ctr;
  logic [CNT_W-1:0]   r_steps_left;
  logic               r_load;
  logic               r_busy;
  logic               r_done;
`ifdef NCO_SWEEP_BIDIR_EN
  logic               r_bidir;
`endif

  // Sweep sequencer: state, counters and registered outputs in one place so
  // every output is a flop and changes only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_S_IDLE;
      r_ftw        <= '0;
      r_step       <= '0;
      r_count      <= '0;
      r_dwell      <= '0;
      r_dwell_ctr  <= '0;
      r_steps_left <= '0;
      r_load       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      r_bidir      <= 1'b0;
`endif
    end else begin
      // Strobes default low; they are raised only on the edge that needs them.
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          // Abort outranks start so a held abort keeps the block parked.
          if (i_start && !i_abort) begin
            r_step       <= i_ftw_step;
            r_count      <= i_step_count;
            r_dwell      <= i_dwell;
            r_ftw        <= i_ftw_start;
            r_load       <= 1'b1;
            r_dwell_ctr  <= i_dwell;
            r_steps_left <= i_step_count;
            r_busy       <= 1'b1;
            r_state      <= c_S_RUN;
`ifdef NCO_SWEEP_BIDIR_EN
            r_bidir      <= i_bidir;
`endif
          end
        end

        c_S_RUN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= c_S_IDLE;
          end else if (r_dwell_ctr != '0) begin
            r_dwell_ctr <= r_dwell_ctr - c_DWELL_ONE;
          end else if (r_steps_left != '0) begin
            r_ftw        <= r_ftw + r_step;
            r_load       <= 1'b1;
            r_steps_left <= r_steps_left - c_CNT_ONE;
            r_dwell_ctr  <= r_dwell;
          end else begin
`ifdef NCO_SWEEP_BIDIR_EN
            // Turn around at the top: the first down word is issued on the
            // same edge, so one of the step_count down steps is used here.
            if (r_bidir && (r_count != '0)) begin
              r_ftw        <= r_ftw - r_step;
              r_load       <= 1'b1;
              r_steps_left <= r_count - c_CNT_ONE;
              r_dwell_ctr  <= r_dwell;
              r_state      <= c_S_RUN_DN;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= c_S_DONE;
            end
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_S_DONE;
`endif
          end
        end

`ifdef NCO_SWEEP_BIDIR_EN
        c_S_RUN_DN: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= c_S_IDLE;
          end else if (r_dwell_ctr != '0) begin
            r_dwell_ctr <= r_dwell_ctr - c_DWELL_ONE;
          end else if (r_steps_left != '0) begin
            r_ftw        <= r_ftw - r_step;
            r_load       <= 1'b1;
            r_steps_left <= r_steps_left - c_CNT_ONE;
            r_dwell_ctr  <= r_dwell;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_S_DONE;
          end
        end
`endif

        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign o_ftw_out  = r_ftw;
  assign o_ftw_load = r_load;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Purpose  : Directed self-checking bench for nco_sweep_ctrl. Each cycle the
//            packed tuple {load, busy, done, ftw_out} is compared with a
//            hand-written expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

  localparam int FTW_W   = 24;
  localparam int CNT_W   = 12;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               rst_n;
  logic               i_start;
  logic               i_abort;
  logic [FTW_W-1:0]   i_ftw_start;
  logic [FTW_W-1:0]   i_ftw_step;
  logic [CNT_W-1:0]   i_step_count;
  logic [DWELL_W-1:0] i_dwell;
`ifdef NCO_SWEEP_BIDIR_EN
  logic               i_bidir;
`endif
  logic [FTW_W-1:0]   o_ftw_out;
  logic               o_ftw_load;
  logic               o_busy;
  logic               o_done;

  int n_checks = 0;
  int n_errors = 0;

  nco_sweep_ctrl #(
    .FTW_W  (FTW_W),
    .CNT_W  (CNT_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_ftw_start (i_ftw_start),
    .i_ftw_step  (i_ftw_step),
    .i_step_count(i_step_count),
    .i_dwell     (i_dwell),
`ifdef NCO_SWEEP_BIDIR_EN
    .i_bidir     (i_bidir),
`endif
    .o_ftw_out   (o_ftw_out),
    .o_ftw_load  (o_ftw_load),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input logic [FTW_W-1:0] fs, input logic [FTW_W-1:0] st,
                            input logic [CNT_W-1:0] sc, input logic [DWELL_W-1:0] dw);
    i_ftw_start  = fs;
    i_ftw_step   = st;
    i_step_count = sc;
    i_dwell      = dw;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== 27'd0) begin
      n_errors++;
      $display("FAIL reset_values got{load,busy,done,ftw}=%h exp=%h", got, 27'd0);
    end
    rst_n = 1'b1;
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== 27'd0) begin
      n_errors++;
      $display("FAIL idle_after_reset got=%h exp=%h", got, 27'd0);
    end
  endtask

  // Basic sweep; inputs are disturbed mid-sweep to prove they were latched.
  task automatic test_basic(input string tag);
    logic [FTW_W-1:0] exp_out [14];
    logic [13:0]      exp_load;
    logic [26:0]      got;
    logic [26:0]      exp;
    exp_out  = '{24'h100, 24'h100, 24'h100, 24'h110, 24'h110, 24'h110, 24'h120,
                 24'h120, 24'h120, 24'h130, 24'h130, 24'h130, 24'h130, 24'h130};
    exp_load = 14'b00_0010_0100_1001;
    set_params(24'h000100, 24'h000010, 12'd3, 16'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      got = {o_ftw_load, o_busy, o_done, o_ftw_out};
      exp = {exp_load[c], (c <= 11), (c == 12), exp_out[c]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got{load,busy,done,ftw}=%h exp=%h", tag, c, got, exp);
      end
      if (c == 1) begin
        set_params(24'hABCDEF, 24'h000777, 12'd9, 16'd0);
        i_start = 1'b1;
      end
      if (c == 2) i_start = 1'b0;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [FTW_W-1:0] exp_out [4];
    logic [26:0]      got;
    logic [26:0]      exp;
    exp_out = '{24'hFFFFF0, 24'h000000, 24'h000000, 24'h000000};
    set_params(24'hFFFFF0, 24'h000010, 12'd1, 16'd0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      got = {o_ftw_load, o_busy, o_done, o_ftw_out};
      exp = {(c <= 1), (c <= 1), (c == 2), exp_out[c]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL wrap cyc=%0d got{load,busy,done,ftw}=%h exp=%h", c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [FTW_W-1:0] exp_out [10];
    logic [26:0]      got;
    logic [26:0]      exp;
    exp_out = '{24'h100, 24'h100, 24'h100, 24'h110, 24'h110,
                24'h110, 24'h110, 24'h110, 24'h110, 24'h110};
    set_params(24'h000100, 24'h000010, 12'd3, 16'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      got = {o_ftw_load, o_busy, o_done, o_ftw_out};
      exp = {(c == 0 || c == 3), (c <= 5), 1'b0, exp_out[c]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL abort cyc=%0d got{load,busy,done,ftw}=%h exp=%h", c, got, exp);
      end
      if (c == 4) i_start = 1'b1;
      if (c == 5) begin
        i_start = 1'b0;
        i_abort = 1'b1;
      end
      if (c == 6) i_abort = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [26:0] got;
    set_params(24'h000100, 24'h000010, 12'd3, 16'd2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== {3'b010, 24'h000120}) begin
      n_errors++;
      $display("FAIL pre_reset cyc=7 got=%h exp=%h", got, {3'b010, 24'h000120});
    end
    rst_n = 1'b0;
    #1;
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== 27'd0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=%h", got, 27'd0);
    end
    tick();
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== 27'd0) begin
      n_errors++;
      $display("FAIL reset_held got=%h exp=%h", got, 27'd0);
    end
    rst_n = 1'b1;
    tick();
    test_basic("after_reset");
  endtask

  // Prior state: idle with ftw_out = 0x130 from the preceding basic sweep.
  task automatic test_degenerate();
    logic [26:0] got;
    set_params(24'hABCDEF, 24'h000001, 12'd0, 16'd0);
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== {3'b000, 24'h000130}) begin
      n_errors++;
      $display("FAIL degen_abort_blocks got=%h exp=%h", got, {3'b000, 24'h000130});
    end
    i_abort = 1'b0;
    tick();
    i_start = 1'b0;
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== {3'b110, 24'hABCDEF}) begin
      n_errors++;
      $display("FAIL degen_cyc0 got=%h exp=%h", got, {3'b110, 24'hABCDEF});
    end
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== {3'b001, 24'hABCDEF}) begin
      n_errors++;
      $display("FAIL degen_cyc1 got=%h exp=%h", got, {3'b001, 24'hABCDEF});
    end
    tick();
    got = {o_ftw_load, o_busy, o_done, o_ftw_out};
    n_checks++;
    if (got !== {3'b000, 24'hABCDEF}) begin
      n_errors++;
      $display("FAIL degen_cyc2 got=%h exp=%h", got, {3'b000, 24'hABCDEF});
    end
  endtask

  // start held from the DONE cycle: ignored in DONE, accepted in IDLE.
  task automatic test_back_to_back();
    logic [FTW_W-1:0] exp_out [7];
    logic [6:0]       exp_load;
    logic [6:0]       exp_busy;
    logic [6:0]       exp_done;
    logic [26:0]      got;
    logic [26:0]      exp;
    exp_out  = '{24'h111111, 24'h111111, 24'h111111, 24'h111111,
                 24'h222222, 24'h222222, 24'h222222};
    exp_load = 7'b001_0001;
    exp_busy = 7'b011_0011;
    exp_done = 7'b100_0100;
    set_params(24'h111111, 24'h000005, 12'd0, 16'd1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      got = {o_ftw_load, o_busy, o_done, o_ftw_out};
      exp = {exp_load[c], exp_busy[c], exp_done[c], exp_out[c]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL b2b cyc=%0d got{load,busy,done,ftw}=%h exp=%h", c, got, exp);
      end
      if (c == 2) begin
        i_ftw_start = 24'h222222;
        i_start     = 1'b1;
      end
      if (c == 4) i_start = 1'b0;
      tick();
    end
  endtask

`ifdef NCO_SWEEP_BIDIR_EN
  task automatic test_bidir();
    logic [FTW_W-1:0] exp_out [12];
    logic [11:0]      exp_load;
    logic [26:0]      got;
    logic [26:0]      exp;
    exp_out  = '{24'h100, 24'h100, 24'h110, 24'h110, 24'h120, 24'h120,
                 24'h110, 24'h110, 24'h100, 24'h100, 24'h100, 24'h100};
    exp_load = 12'b0001_0101_0101;
    set_params(24'h000100, 24'h000010, 12'd2, 16'd1);
    i_bidir = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_bidir = 1'b0;
    for (int c = 0; c < 12; c++) begin
      got = {o_ftw_load, o_busy, o_done, o_ftw_out};
      exp = {exp_load[c], (c <= 9), (c == 10), exp_out[c]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL bidir cyc=%0d got{load,busy,done,ftw}=%h exp=%h", c, got, exp);
      end
      tick();
    end
  endtask
`endif

  initial begin
    i_start = 1'b0;
    i_abort = 1'b0;
    set_params('0, '0, '0, '0);
`ifdef NCO_SWEEP_BIDIR_EN
    i_bidir = 1'b0;
`endif
    test_reset();
    test_basic("basic");
    test_wrap();
    test_abort();
    test_reset_mid_sweep();
    test_degenerate();
    test_back_to_back();
`ifdef NCO_SWEEP_BIDIR_EN
    test_bidir();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the NCO used in the UP5K speed-test designs. It steps the NCO frequency tuning word (FTW) through a programmed linear sweep: a start value, a fixed increment, a step count and a per-step dwell time. It sits between the control logic and the phase accumulator, which samples `ftw_out` whenever `ftw_load` pulses.

## Interface
- `FTW_W`, 24, tuning-word width
- `CNT_W`, 12, step-count width
- `DWELL_W`, 16, dwell-counter width

- `clk` in 1: single system clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin sweep; sampled only in IDLE
- `abort` in 1: terminate sweep
- `ftw_start` in FTW_W: first tuning word
- `ftw_step` in FTW_W: per-step increment
- `step_count` in CNT_W: number of increments after the first word
- `dwell` in DWELL_W: hold time per word, minus one
- `bidir` in 1: present only with `NCO_SWEEP_BIDIR_EN`
- `ftw_out` out FTW_W: current tuning word
- `ftw_load` out 1: one-cycle strobe; `ftw_out` is new this cycle
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle completion strobe

## Operation
- **States:** IDLE, RUN, DONE. RUN is split into RUN_UP and RUN_DN when the macro is defined.
- **IDLE, `start`=1, `abort`=0:**
  - Latch `ftw_step`, `step_count`, `dwell`.
  - Set `ftw_out`<=`ftw_start`, pulse `ftw_load`, set `dwell_ctr`<=`dwell`, set `steps_left`<=`step_count`.
  - Next state is RUN.
- **RUN, `dwell_ctr`!=0:** decrement `dwell_ctr`; `ftw_out` holds.
- **RUN, `dwell_ctr`==0, `steps_left`!=0:**
  - `ftw_out`<=`ftw_out`+`ftw_step`, modulo 2^FTW_W (wraps, no saturation).
  - Pulse `ftw_load`, decrement `steps_left`, reload `dwell_ctr`.
- **RUN, `dwell_ctr`==0, `steps_left`==0:** go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. `ftw_out` keeps the last value indefinitely.
- **`abort`:**
  - In RUN: go to IDLE on the next edge; no `done` pulse; `ftw_out` holds.
  - In IDLE: blocks `start` (abort has priority); state stays IDLE.
- **Boundary cases:**
  - `start` while not IDLE: ignored. Latched parameters are immune to input changes during a sweep.
  - `step_count`=0: exactly one load, then DONE after `dwell`+1 cycles.
  - `dwell`=0: a new word on every cycle.
- **Reset:** `rst_n` low at any time, including mid-sweep, asynchronously forces IDLE.
  - Reset values: `ftw_out`=0, `ftw_load`=0, `busy`=0, `done`=0, all counters 0.
- **Outputs:** `busy`=1 exactly while in RUN. All outputs are registered.

## Timing
- Cycle *n* means the interval after rising edge *n*. `start` is sampled at edge 0.
- First load: `ftw_load`=1 in cycle 0 with `ftw_out`=`ftw_start` (one-edge latency).
- Loads are spaced exactly `dwell`+1 cycles apart. A sweep has `step_count`+1 loads.
- `done` is asserted in cycle (`step_count`+1)×(`dwell`+1).
- `busy` is 1 from cycle 0 through the cycle before `done`.
- The earliest new `start` is sampled in the cycle after `done`.

## Configuration
- **`NCO_SWEEP_BIDIR_EN` defined:**
  - Adds the `bidir` input, latched at `start`.
  - With `bidir`=1, the sweep reverses when the up-sweep would otherwise enter DONE. It enters RUN_DN, reloads `steps_left` with `step_count`, and subtracts `ftw_step` (modulo 2^FTW_W) with the same dwell spacing back to `ftw_start`.
  - A bidirectional sweep has 2×`step_count`+1 loads. The first down load follows the last up word by `dwell`+1 cycles.
  - With `bidir`=0, behaviour is identical to the build without the macro.
- **Undefined:** the port is absent, the sweep is up-only, and the RUN_DN logic is not synthesized.

## Test plan
- Basic sweep:
  - Stimulus: `ftw_start`=0x000100, `ftw_step`=0x000010, `step_count`=3, `dwell`=2.
  - Required: loads in cycles 0, 3, 6, 9 with values 0x100, 0x110, 0x120, 0x130; `done` in cycle 12; `busy` high in cycles 0–11.
- Wrap and fast step:
  - Stimulus: `ftw_start`=0xFFFFF0, `ftw_step`=0x000010, `step_count`=1, `dwell`=0.
  - Required: loads 0xFFFFF0, then 0x000000 in consecutive cycles; `done` in cycle 2.
- Abort and ignored start:
  - Stimulus: `abort` pulsed in cycle 5 of the basic sweep.
  - Required: IDLE in cycle 6, `ftw_out`=0x110 holds, no `done`. A `start` sampled in cycle 4 has no effect.
- Reset mid-sweep:
  - Stimulus: `rst_n` low for 2 cycles during cycle 7 of the basic sweep.
  - Required: immediate `ftw_out`=0 and `busy`=0; a fresh `start` afterwards reproduces the basic-sweep response.
- Degenerate sweep:
  - Stimulus: `step_count`=0, `dwell`=0, `start` with `abort`=1 in IDLE.
  - Required: no load. A `start` in the next cycle gives one load in cycle 0 and `done` in cycle 1.
- Bidirectional (macro defined):
  - Stimulus: `bidir`=1, `ftw_start`=0x100, `ftw_step`=0x10, `step_count`=2, `dwell`=1.
  - Required: loads 0x100, 0x110, 0x120, 0x110, 0x100 in cycles 0, 2, 4, 6, 8; `done` in cycle 10.
